// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: turns the four raw push-buttons into clean single-cycle
// move/drop/rotate command pulses. Each button is synchronised and debounced.
// Left, right and down auto-repeat while held. Rotate fires once per press.
module tetris_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned REPEAT_DELAY    = 12,
  parameter int unsigned REPEAT_RATE     = 4
) (
  input  logic       gm_clk,
  input  logic       gm_rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_rot,
  output logic       left,
  output logic       right,
  output logic       down,
  output logic       rott,
  output logic [3:0] held
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TM_W   = $clog2(TM_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LOAD = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] RATE_LOAD  = TM_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  // Button vectors are ordered {rot, down, right, left}
  logic [3:0]      raw;
  logic [3:0]      s1_q, s1_d, s2_q, s2_d;
  logic [3:0]      stable_q, stable_d;
  logic [DB_W-1:0] cnt_q [4];
  logic [DB_W-1:0] cnt_d [4];

  // Repeat channels are ordered {down, right, left}
  logic [2:0]      act_q, act_d;
  rep_state_e      state_q [3];
  rep_state_e      state_d [3];
  logic [TM_W-1:0] timer_q [3];
  logic [TM_W-1:0] timer_d [3];
  logic [2:0]      pulse;
  logic [3:0]      cmd_q, cmd_d;

  assign raw = {btn_rot, btn_down, btn_right, btn_left};

  // Two-flop synchroniser inputs
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
  end

  // Debounce: count consecutive disagreeing cycles; any agreement restarts the count
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Effective activity per repeat channel. Left and right count as active only
  // when held alone, so a conflict parks both in IDLE and the survivor of a
  // conflict sees a fresh rising edge of its activity.
  always_comb begin
    act_q = {stable_q[2], stable_q[1] & ~stable_q[0], stable_q[0] & ~stable_q[1]};
    act_d = {stable_d[2], stable_d[1] & ~stable_d[0], stable_d[0] & ~stable_d[1]};
  end

  // Repeat FSM next-state logic
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      if (!act_d[i]) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE:    if (!act_q[i]) state_d[i] = DELAY;
          DELAY:   if (timer_q[i] == '0) state_d[i] = REPEAT;
          REPEAT:  state_d[i] = REPEAT;
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // Repeat FSM outputs: command pulse and timer reload/decrement
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      pulse[i]   = 1'b0;
      timer_d[i] = timer_q[i];
      if (!act_d[i]) begin
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (!act_q[i]) begin
              pulse[i]   = 1'b1;
              timer_d[i] = DELAY_LOAD;
            end
          end
          DELAY, REPEAT: begin
            if (timer_q[i] == '0) begin
              pulse[i]   = 1'b1;
              timer_d[i] = RATE_LOAD;
            end else begin
              timer_d[i] = timer_q[i] - 1'b1;
            end
          end
          default: timer_d[i] = '0;
        endcase
      end
    end
  end

  // Registered command outputs; rotate pulses on its press event only
  always_comb begin
    cmd_d = {stable_d[3] & ~stable_q[3], pulse};
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge gm_clk or posedge gm_rst) begin
    if (gm_rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cmd_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cmd_q    <= cmd_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      for (int unsigned i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign left  = cmd_q[0];
  assign right = cmd_q[1];
  assign down  = cmd_q[2];
  assign rott  = cmd_q[3];
  assign held  = stable_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl: default-parameter instance plus a
// fast corner instance (DEBOUNCE_CYCLES=1, REPEAT_DELAY=2, REPEAT_RATE=1).
module tb_tetris_input_ctrl;

  logic       gm_clk = 1'b0;
  logic       gm_rst;
  logic       btn_left, btn_right, btn_down, btn_rot;
  logic       left, right, down, rott;
  logic [3:0] held;
  logic       c_btn_left, c_btn_right, c_btn_down, c_btn_rot;
  logic       c_left, c_right, c_down, c_rott;
  logic [3:0] c_held;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 gm_clk = ~gm_clk;

  tetris_input_ctrl dut (
    .gm_clk(gm_clk), .gm_rst(gm_rst),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .btn_rot(btn_rot),
    .left(left), .right(right), .down(down), .rott(rott), .held(held)
  );

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(1),
    .REPEAT_DELAY(2),
    .REPEAT_RATE(1)
  ) dut_fast (
    .gm_clk(gm_clk), .gm_rst(gm_rst),
    .btn_left(c_btn_left), .btn_right(c_btn_right), .btn_down(c_btn_down), .btn_rot(c_btn_rot),
    .left(c_left), .right(c_right), .down(c_down), .rott(c_rott), .held(c_held)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge for sampling/driving
  task automatic step();
    @(posedge gm_clk);
    @(negedge gm_clk);
  endtask

  initial begin
    gm_rst = 1'b1;
    {btn_left, btn_right, btn_down, btn_rot} = '0;
    {c_btn_left, c_btn_right, c_btn_down, c_btn_rot} = '0;
    repeat (3) step();

    // Reset state
    check_eq("rst_cmds", 32'({left, right, down, rott}), 32'h0);
    check_eq("rst_held", 32'(held), 32'h0);
    check_eq("rst_fast", 32'({c_left, c_right, c_down, c_rott, c_held}), 32'h0);
    gm_rst = 1'b0;
    step();

    // Clean rotate press: one pulse after edge 4, held[3] follows debounced level
    btn_rot = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      check_eq($sformatf("rot_pulse e%0d", e), 32'(rott), 32'(e == 4));
      check_eq($sformatf("rot_held e%0d", e), 32'(held[3]), 32'(e >= 4));
    end
    btn_rot = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      check_eq($sformatf("rot_rel_pulse e%0d", e), 32'(rott), 32'h0);
      check_eq($sformatf("rot_rel_held e%0d", e), 32'(held[3]), 32'(e < 4));
    end

    // Bouncy left press: raw 1,0,1,0 then steady 1 from edge 4; pulse at edge 8
    for (int e = 0; e < 14; e++) begin
      btn_left = (e == 0 || e == 2 || e >= 4);
      step();
      check_eq($sformatf("bounce_pulse e%0d", e), 32'(left), 32'(e == 8));
      check_eq($sformatf("bounce_held e%0d", e), 32'(held[0]), 32'(e >= 8));
    end
    btn_left = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      check_eq($sformatf("bounce_rel_pulse e%0d", e), 32'(left), 32'h0);
      check_eq($sformatf("bounce_rel_held e%0d", e), 32'(held[0]), 32'(e < 4));
    end

    // Auto-repeat on down: pulses at 4, 16, 20, ..., 36, then 40 before release lands at 44
    btn_down = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step();
      check_eq($sformatf("rep_pulse e%0d", e), 32'(down),
               32'(e == 4 || (e >= 16 && (e - 16) % 4 == 0)));
    end
    btn_down = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      check_eq($sformatf("rep_rel_pulse e%0d", e), 32'(down), 32'(e == 0));
      check_eq($sformatf("rep_rel_held e%0d", e), 32'(held[2]), 32'(e < 4));
    end

    // Left/right conflict: left press at 4, right raw at 10 (held 14), left raw
    // drop at 25 (held falls 29), right raw drop at 47 (held falls 51)
    btn_left = 1'b1;
    for (int e = 0; e < 57; e++) begin
      step();
      check_eq($sformatf("cf_left e%0d", e), 32'(left), 32'(e == 4));
      check_eq($sformatf("cf_right e%0d", e), 32'(right),
               32'(e == 29 || e == 41 || e == 45 || e == 49));
      check_eq($sformatf("cf_held e%0d", e), 32'(held[1:0]),
               32'({(e >= 14 && e < 51), (e >= 4 && e < 29)}));
      if (e == 9)  btn_right = 1'b1;
      if (e == 24) btn_left  = 1'b0;
      if (e == 46) btn_right = 1'b0;
    end

    // Reset while repeating: down high after edge 20, reset drops it at once
    btn_down = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      step();
      check_eq($sformatf("mr_pulse e%0d", e), 32'(down),
               32'(e == 4 || e == 16 || e == 20));
    end
    gm_rst = 1'b1;
    #1;
    check_eq("mr_async_down", 32'(down), 32'h0);
    check_eq("mr_async_held", 32'(held), 32'h0);
    step();
    step();
    gm_rst = 1'b0;
    for (int e = 0; e < 7; e++) begin
      step();
      check_eq($sformatf("mr_post_pulse e%0d", e), 32'({left, right, down, rott}),
               32'({1'b0, 1'b0, (e == 4), 1'b0}));
      check_eq($sformatf("mr_post_held e%0d", e), 32'(held[2]), 32'(e >= 4));
    end
    btn_down = 1'b0;
    repeat (10) step();
    check_eq("mr_settle", 32'({down, held}), 32'h0);

    // Fast corner: press at edge 2, gap at 3, continuous from 4 until release lands
    c_btn_left = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      check_eq($sformatf("fast_left e%0d", e), 32'(c_left), 32'(e == 2 || e >= 4));
    end
    c_btn_left = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      check_eq($sformatf("fast_rel_left e%0d", e), 32'(c_left), 32'(e < 2));
      check_eq($sformatf("fast_rel_held e%0d", e), 32'(c_held[0]), 32'(e < 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
